// File: rtl/central_mem_pkg.sv
// central_mem_pkg: shared widths and the decoded-address record for the banked memory.
package central_mem_pkg;
  localparam int BSEL_W = 3;
  localparam int ERR_W = 16;
  localparam int LOCAL_W = 16;
  typedef struct packed {
    logic in_range;
    logic [BSEL_W-1:0] bank;
    logic [LOCAL_W-1:0] local_addr;
  } dec_t;
endpackage

// File: rtl/banked_data_memory_if.sv
// banked_data_memory_if: read/write request and response bundle of the banked memory.
interface banked_data_memory_if #(parameter int WIDTH = 32) ();
  import central_mem_pkg::*;
  logic rd_req;
  logic [WIDTH-1:0] rd_addr;
  logic rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic rd_err;
  logic wr_req;
  logic [WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic wr_err;
  logic [ERR_W-1:0] err_count;
  modport master (output rd_req, rd_addr, wr_req, wr_addr, wr_data,
                  input rd_valid, rd_data, rd_err, wr_err, err_count);
  modport slave (input rd_req, rd_addr, wr_req, wr_addr, wr_data,
                 output rd_valid, rd_data, rd_err, wr_err, err_count);
endinterface

// File: rtl/mem_bank.sv
// mem_bank: one-write/one-read synchronous RAM with registered read, contents uninitialised.
module mem_bank #(
  parameter int DATA_W = 8,
  parameter int AW = 16
) (
  input  logic clock,
  input  logic we,
  input  logic [AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic re,
  input  logic [AW-1:0] ra,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [2**AW];
  always_ff @(posedge clock) begin
    if (we) mem[wa] <= wd;
    if (re) q <= mem[ra];
  end
endmodule

// File: rtl/banked_data_memory.sv
// banked_data_memory: address-decoded bank array with write-first forwarding and a
// three-edge read pipeline (RAM read, bank select, output register).
module banked_data_memory
  import central_mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DATA_W = 8,
  parameter int BANK_AW = LOCAL_W,
  parameter int NUM_BANKS = 3,
  parameter int FIRST_BANK = 3,
  parameter logic [WIDTH-1:0] BASE_ADDR = 32'h0000_4000
) (
  input logic clock,
  input logic reset_n,
  banked_data_memory_if.slave bus
);
  // Borrow out of the subtraction lands in o[WIDTH] and marks addresses below BASE_ADDR.
  function automatic dec_t decode(input logic [WIDTH-1:0] a);
    logic [WIDTH:0] o;
    logic [BSEL_W-1:0] i;
    o = {1'b0, a} - {1'b0, BASE_ADDR};
    i = o[BANK_AW+2:BANK_AW];
    decode.in_range = !o[WIDTH] && o[WIDTH-1:BANK_AW+3] == '0 &&
                      int'(i) >= FIRST_BANK && int'(i) < FIRST_BANK + NUM_BANKS;
    decode.bank = i - BSEL_W'(FIRST_BANK);
    decode.local_addr = o[BANK_AW-1:0];
  endfunction
  dec_t wd, rdd;
  logic wr_ok, wr_rej;
  logic [DATA_W-1:0] q [2**BSEL_W];
  logic s1_valid, s1_err, s1_fwd, s2_valid, s2_err;
  logic [BSEL_W-1:0] s1_bank;
  logic [DATA_W-1:0] s1_fwd_data, s2_data;
  logic [ERR_W:0] cnt_sum;
  assign wd = decode(bus.wr_addr);
  assign rdd = decode(bus.rd_addr);
  assign wr_ok = bus.wr_req && wd.in_range && reset_n;
  assign wr_rej = bus.wr_req && !wd.in_range;
  assign cnt_sum = {1'b0, bus.err_count} + (ERR_W+1)'(s2_err) + (ERR_W+1)'(wr_rej);
  for (genvar b = 0; b < 2**BSEL_W; b++) begin : g_bank
    if (b < NUM_BANKS) begin : g_ram
      mem_bank #(.DATA_W(DATA_W), .AW(BANK_AW)) u_bank (
        .clock(clock),
        .we(wr_ok && wd.bank == BSEL_W'(b)),
        .wa(wd.local_addr),
        .wd(bus.wr_data[DATA_W-1:0]),
        .re(bus.rd_req && rdd.in_range && rdd.bank == BSEL_W'(b)),
        .ra(rdd.local_addr),
        .q(q[b])
      );
    end else begin : g_none
      assign q[b] = '0;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_err <= 1'b0;
      s1_fwd <= 1'b0;
      s1_bank <= '0;
      s1_fwd_data <= '0;
      s2_valid <= 1'b0;
      s2_err <= 1'b0;
      s2_data <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_err <= 1'b0;
      bus.rd_data <= '0;
      bus.wr_err <= 1'b0;
      bus.err_count <= '0;
    end else begin
      s1_valid <= bus.rd_req;
      s1_err <= !rdd.in_range;
      s1_bank <= rdd.bank;
      // The RAM reads old data when written on the same edge, so capture the write instead.
      s1_fwd <= wr_ok && bus.wr_addr == bus.rd_addr;
      s1_fwd_data <= bus.wr_data[DATA_W-1:0];
      s2_valid <= s1_valid;
      s2_err <= s1_valid && s1_err;
      s2_data <= !s1_valid || s1_err ? '0 : s1_fwd ? s1_fwd_data : q[s1_bank];
      bus.rd_valid <= s2_valid;
      bus.rd_err <= s2_err;
      bus.rd_data <= WIDTH'(s2_data);
      bus.wr_err <= wr_rej;
      bus.err_count <= cnt_sum[ERR_W] ? '1 : cnt_sum[ERR_W-1:0];
    end
  end
endmodule

// File: tb/tb_banked_data_memory.sv
// tb_banked_data_memory: directed stimulus, an address-map reference model checked every
// cycle, and literal expectations for the documented scenarios.
module tb_banked_data_memory;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;
  banked_data_memory_if #(.WIDTH(32)) bus ();
  banked_data_memory dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));
  always #5 clock = ~clock;

  typedef struct {
    int due;
    bit err;
    bit known;
    logic [7:0] data;
  } rexp_t;
  rexp_t rq[$];
  logic [7:0] mm [int];
  int cyc = 0;
  bit m_valid = 0, m_err = 0, m_known = 1, m_wr_err = 0;
  logic [7:0] m_data = 0;
  logic [15:0] m_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // The map covers banks 3..5 above 0x4000: 0x4000 + 3*64K up to 0x4000 + 6*64K.
  function automatic bit inr(input logic [31:0] a);
    return a >= 32'h0003_4000 && a < 32'h0006_4000;
  endfunction

  function automatic logic [15:0] bump(input logic [15:0] c);
    return c == 16'hFFFF ? c : c + 16'd1;
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      rq.delete();
      m_cnt = 0;
      m_wr_err = 0;
      m_valid = 0;
      m_err = 0;
      m_known = 1;
      m_data = 0;
    end else begin
      rexp_t r;
      cyc++;
      m_valid = 0;
      m_err = 0;
      m_known = 1;
      m_data = 0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        m_valid = 1;
        m_err = r.err;
        m_known = r.known;
        m_data = r.err ? 8'h00 : r.data;
        if (r.err) m_cnt = bump(m_cnt);
      end
      m_wr_err = bus.wr_req && !inr(bus.wr_addr);
      if (m_wr_err) m_cnt = bump(m_cnt);
      else if (bus.wr_req) mm[int'(bus.wr_addr)] = bus.wr_data[7:0];
      if (bus.rd_req) begin
        r.due = cyc + 2;
        r.err = !inr(bus.rd_addr);
        r.known = !inr(bus.rd_addr) || mm.exists(int'(bus.rd_addr));
        r.data = (inr(bus.rd_addr) && mm.exists(int'(bus.rd_addr))) ? mm[int'(bus.rd_addr)] : 8'h00;
        rq.push_back(r);
      end
    end
  end

  always @(posedge clock) begin
    #1;
    chk("m_rd_valid", {31'b0, bus.rd_valid}, {31'b0, m_valid});
    chk("m_rd_err", {31'b0, bus.rd_err}, {31'b0, m_err});
    if (m_known) chk("m_rd_data", bus.rd_data, {24'b0, m_data});
    chk("m_wr_err", {31'b0, bus.wr_err}, {31'b0, m_wr_err});
    chk("m_err_count", {16'b0, bus.err_count}, {16'b0, m_cnt});
  end

  task automatic set(input bit r, input logic [31:0] ra, input bit w, input logic [31:0] wa, input logic [31:0] wd);
    bus.rd_req = r;
    bus.rd_addr = ra;
    bus.wr_req = w;
    bus.wr_addr = wa;
    bus.wr_data = wd;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    set(0, 0, 1, a, d);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] d, input bit e);
    @(negedge clock);
    set(1, a, 0, 0, 0);
    @(negedge clock);
    set(0, 0, 0, 0, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    chk({nm, "_valid"}, {31'b0, bus.rd_valid}, 32'd1);
    chk({nm, "_data"}, bus.rd_data, d);
    chk({nm, "_err"}, {31'b0, bus.rd_err}, {31'b0, e});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ba [4];
    logic [31:0] bd [4];
    set(0, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    chk("rst_wr_err", {31'b0, bus.wr_err}, 32'd0);
    chk("rst_err_count", {16'b0, bus.err_count}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    wr(32'h0003_4010, 32'hFFFF_FFA5);
    rd_chk("rd_34010", 32'h0003_4010, 32'h0000_00A5, 0);
    wr(32'h0006_3FFF, 32'h0000_003C);
    rd_chk("rd_63fff", 32'h0006_3FFF, 32'h0000_003C, 0);
    wr(32'h0004_4000, 32'h0000_0011);
    rd_chk("rd_44000", 32'h0004_4000, 32'h0000_0011, 0);
    rd_chk("rd_borrow", 32'h0000_3FFF, 32'h0, 1);
    rd_chk("rd_idx6", 32'h0006_4000, 32'h0, 1);
    chk("cnt_after_rd_err", {16'b0, bus.err_count}, 32'd2);
    @(negedge clock);
    set(0, 0, 1, 32'h0000_0020, 32'h5);
    @(negedge clock);
    set(0, 0, 0, 0, 0);
    chk("wr_err_pulse", {31'b0, bus.wr_err}, 32'd1);
    chk("cnt_after_wr_err", {16'b0, bus.err_count}, 32'd3);
    @(posedge clock);
    #1;
    chk("wr_err_drop", {31'b0, bus.wr_err}, 32'd0);
    @(negedge clock);
    set(1, 32'h0000_3FFF, 0, 0, 0);
    @(negedge clock);
    set(0, 0, 0, 0, 0);
    @(negedge clock);
    set(0, 0, 1, 32'h0000_0000, 32'h0);
    @(negedge clock);
    set(0, 0, 0, 0, 0);
    chk("both_rd_err", {31'b0, bus.rd_err}, 32'd1);
    chk("both_wr_err", {31'b0, bus.wr_err}, 32'd1);
    chk("cnt_plus_two", {16'b0, bus.err_count}, 32'd5);
    @(negedge clock);
    set(1, 32'h0003_4020, 1, 32'h0003_4020, 32'h0000_0077);
    @(negedge clock);
    set(0, 0, 0, 0, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("fwd_valid", {31'b0, bus.rd_valid}, 32'd1);
    chk("fwd_data", bus.rd_data, 32'h0000_0077);
    ba = '{32'h0003_4010, 32'h0006_3FFF, 32'h0004_4000, 32'h0003_4020};
    bd = '{32'hA5, 32'h3C, 32'h11, 32'h77};
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i < 4) set(1, ba[i], 0, 0, 0);
      else set(0, 0, 0, 0, 0);
      @(posedge clock);
      #1;
      if (i >= 2) begin
        chk("b2b_valid", {31'b0, bus.rd_valid}, 32'd1);
        chk("b2b_data", bus.rd_data, bd[i-2]);
      end
    end
    @(negedge clock);
    set(1, 32'h0003_4010, 0, 0, 0);
    @(negedge clock);
    set(1, 32'h0000_3FFF, 0, 0, 0);
    @(negedge clock);
    set(0, 0, 1, 32'h0003_4010, 32'h0000_00EE);
    reset_n = 1'b0;
    #1;
    chk("async_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    chk("async_err_count", {16'b0, bus.err_count}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    set(0, 0, 0, 0, 0);
    repeat (5) @(posedge clock);
    rd_chk("rd_after_rst", 32'h0003_4010, 32'h0000_00A5, 0);
    @(negedge clock);
    set(1, 32'h0, 1, 32'h0, 32'h0);
    repeat (32800) @(posedge clock);
    @(negedge clock);
    set(0, 0, 0, 0, 0);
    chk("cnt_saturated", {16'b0, bus.err_count}, 32'h0000_FFFF);
    repeat (4) @(posedge clock);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/banked_data_memory.md
BANKED_DATA_MEMORY -- requirements
Module: banked_data_memory

Interface
REQ-001 WIDTH, 32, address and data bus width.
REQ-002 DATA_W, 8, stored word width per bank location.
REQ-003 BANK_AW, 16, local address bits per bank (depth 2**BANK_AW).
REQ-004 NUM_BANKS, 3, number of RAM banks (1..8).
REQ-005 FIRST_BANK, 3, bank-select index of bank 0.
REQ-006 BASE_ADDR, 32'h0000_4000, value subtracted from every incoming address.
REQ-007 clock  in  1  single clock, all state on rising edge.
REQ-008 reset_n  in  1  asynchronous active-low reset.
REQ-009 rd_req  in  1  read request, one per cycle allowed.
REQ-010 rd_addr  in  WIDTH  read byte address.
REQ-011 rd_valid  out  1  read result valid, one-cycle pulse per request.
REQ-012 rd_data  out  WIDTH  read data, zero-extended from DATA_W.
REQ-013 rd_err  out  1  qualifies rd_valid: address out of range.
REQ-014 wr_req  in  1  write request, always accepted.
REQ-015 wr_addr  in  WIDTH  write byte address.
REQ-016 wr_data  in  WIDTH  write data, bits [DATA_W-1:0] stored.
REQ-017 wr_err  out  1  one-cycle pulse: previous write dropped, out of range.
REQ-018 err_count  out  16  saturating count of rejected reads plus writes.

Function
REQ-019 Address decode: offset = addr - BASE_ADDR (WIDTH-bit, borrow kept); idx = offset[BANK_AW+2:BANK_AW]; local = offset[BANK_AW-1:0].
REQ-020 Address in range iff no borrow, offset[WIDTH-1:BANK_AW+3] == 0, and FIRST_BANK <= idx < FIRST_BANK+NUM_BANKS; bank = idx - FIRST_BANK.
REQ-021 In-range write: store wr_data[DATA_W-1:0] at bank/local on the same rising edge; exactly one bank write-enabled.
REQ-022 Out-of-range write: no bank written; wr_err = 1 the following cycle only.
REQ-023 Read latency: rd_req sampled at edge N -> rd_valid, rd_data, rd_err valid after edge N+2; fully pipelined, back-to-back requests give back-to-back results in order.
REQ-024 Out-of-range read: rd_valid = 1, rd_err = 1, rd_data = 0 at same latency.
REQ-025 rd_valid = 0 implies rd_data = 0 and rd_err = 0.
REQ-026 Same-cycle read and write to identical in-range address: read returns new wr_data (write-first forwarding).
REQ-027 Write at edge N, read of same address at edge N+1: returns new data.
REQ-028 err_count increments by 1 per rejected read (at its rd_valid) and per rejected write; both in one cycle -> +2; holds at 16'hFFFF.
REQ-029 Bank memory contents undefined after power-up; no initialisation.

Reset
REQ-030 reset_n low: rd_valid, rd_data, rd_err, wr_err = 0, err_count = 0, pipeline valid bits cleared, immediately and asynchronously.
REQ-031 Reads in flight when reset asserts are discarded; no rd_valid after reset release for them.
REQ-032 Writes are ignored while reset_n is low; bank contents are not cleared by reset.

Structure
REQ-033 Shared package central_mem_pkg holds bank-select width (3), the err_count width, and a typedef for the decoded address (in_range, bank, local).
REQ-034 One sub-module mem_bank: 1 write port / 1 read port synchronous RAM, DATA_W x 2**BANK_AW, registered read; instantiated NUM_BANKS times via generate.
REQ-035 Forwarding compare, bank-select mux, and output register live in banked_data_memory.

Verification (defaults: BASE_ADDR 0x4000, FIRST_BANK 3, NUM_BANKS 3)
REQ-036 Write 0x34010 <- 0xA5, read 0x34010 next cycle -> rd_valid two edges later, rd_data 0x0000_00A5, rd_err 0.
REQ-037 Write 0x63FFF <- 0x3C (last bank, last location), read it back -> 0x0000_003C; write 0x44000 <- 0x11 -> bank 1 local 0, read back 0x11.
REQ-038 Read 0x3FFF (borrow) and read 0x64000 (idx 6) -> rd_valid with rd_err 1, rd_data 0; err_count 2.
REQ-039 Same-cycle write 0x34020 <- 0x77 and read 0x34020 -> rd_data 0x77; four back-to-back reads return four in-order results on consecutive cycles.
REQ-040 Issue two reads, assert reset_n low one cycle later -> no rd_valid after release, err_count 0; previously written 0x34010 still reads 0xA5.
